// File: rtl/ipml_prefetch_fifo_v2_0_pkg.sv
// Shared constants and sizing helpers for the prefetch FIFO and its output buffer.
package ipml_prefetch_fifo_pkg;

  localparam int OBUF_DEPTH = 2;

  function automatic int lvl_w(input int depth_w);
    return depth_w + 32'sd1;
  endfunction

  // RAM entries plus the two output-buffer slots
  function automatic int capacity(input int depth_w);
    return (32'sd1 <<< depth_w) + 32'sd2;
  endfunction

endpackage

// File: rtl/ipml_prefetch_fifo_v2_0_obuf.sv
// Two-entry in-order output buffer; the head entry drives the FIFO read port.
module ipml_prefetch_obuf
  import ipml_prefetch_fifo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  input  logic              pop,
  output logic [DATA_W-1:0] out_data,
  output logic              out_vld,
  output logic [1:0]        buf_cnt
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              vld_q, vld_d;
  logic [1:0]        slot_s;

  // Shift on pop, then place the incoming word behind whatever remains
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    slot_s = cnt_q - {1'b0, pop};
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      if (pop) begin
        head_d = tail_q;
      end else begin
        head_d = head_q;
      end
      if (in_vld) begin
        if (slot_s == 2'd0) begin
          head_d = in_data;
        end else begin
          tail_d = in_data;
        end
      end else begin
        tail_d = tail_q;
      end
      cnt_d = cnt_q + {1'b0, in_vld} - {1'b0, pop};
    end
    vld_d = (cnt_d != 2'd0);
  end

  // Buffer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= {DATA_W{1'b0}};
      tail_q <= {DATA_W{1'b0}};
      cnt_q  <= 2'd0;
      vld_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
    end
  end

  assign out_data = head_q;
  assign out_vld  = vld_q;
  assign buf_cnt  = cnt_q;

endmodule

// File: rtl/ipml_prefetch_fifo_v2_0.sv
// First-word-fall-through FIFO: simple-dual-port RAM prefetching into a 2-entry
// output buffer, with flush, level thresholds and sticky error flags.
module ipml_prefetch_fifo_v2_0
  import ipml_prefetch_fifo_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH_W  = 10,
  parameter int AF_LEVEL = 32'sd1 <<< DEPTH_W,
  parameter int AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic              wr_vld,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_en,
  output logic              rd_vld,
  output logic [DEPTH_W:0]  level,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int               LVL_W      = lvl_w(DEPTH_W);
  localparam int               RAM_DEPTH  = 32'sd1 <<< DEPTH_W;
  localparam logic [DEPTH_W:0] RAM_FULL   = {1'b1, {DEPTH_W{1'b0}}};
  localparam logic [LVL_W-1:0] AF_THR     = LVL_W'(AF_LEVEL);
  localparam logic [LVL_W-1:0] AE_THR     = LVL_W'(AE_LEVEL);
  localparam logic [2:0]       OBUF_SLOTS = 3'(OBUF_DEPTH);

  logic [DATA_W-1:0] mem_q [RAM_DEPTH];
  logic [DATA_W-1:0] ram_rdata_q;
  logic [DEPTH_W:0]  wptr_q, wptr_d, rptr_q, rptr_d, ram_cnt_s;
  logic              inflight_q, inflight_d;
  logic              wr_vld_q, wr_vld_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              af_q, af_d, ae_q, ae_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              push_s, pop_s, issue_s, rd_vld_s;
  logic [1:0]        buf_cnt_s;
  logic [2:0]        occ_s;

  // Issue a RAM read only when the buffer can absorb the word one cycle later
  always_comb begin
    push_s    = wr_en & wr_vld_q & ~flush;
    pop_s     = rd_en & rd_vld_s & ~flush;
    ram_cnt_s = wptr_q - rptr_q;
    occ_s     = {1'b0, buf_cnt_s} + {2'b00, inflight_q} - {2'b00, pop_s};
    issue_s   = (ram_cnt_s != {(DEPTH_W+1){1'b0}}) && (occ_s < OBUF_SLOTS) && !flush;
    if (flush) begin
      wptr_d     = {(DEPTH_W+1){1'b0}};
      rptr_d     = {(DEPTH_W+1){1'b0}};
      inflight_d = 1'b0;
      level_d    = {LVL_W{1'b0}};
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
    end else begin
      wptr_d     = wptr_q + {{DEPTH_W{1'b0}}, push_s};
      rptr_d     = rptr_q + {{DEPTH_W{1'b0}}, issue_s};
      inflight_d = issue_s;
      level_d    = level_q + {{DEPTH_W{1'b0}}, push_s} - {{DEPTH_W{1'b0}}, pop_s};
      ovf_d      = ovf_q | (wr_en & ~wr_vld_q);
      unf_d      = unf_q | (rd_en & ~rd_vld_s);
    end
    wr_vld_d = ((wptr_d - rptr_d) != RAM_FULL);
    af_d     = (level_d >= AF_THR);
    ae_d     = (level_d <= AE_THR);
  end

  // Control and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= {(DEPTH_W+1){1'b0}};
      rptr_q     <= {(DEPTH_W+1){1'b0}};
      inflight_q <= 1'b0;
      wr_vld_q   <= 1'b0;
      level_q    <= {LVL_W{1'b0}};
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= inflight_d;
      wr_vld_q   <= wr_vld_d;
      level_q    <= level_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Storage array with a registered read port; left unreset so it maps to block RAM
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q[DEPTH_W-1:0]] <= wr_data;
    end
    if (issue_s) begin
      ram_rdata_q <= mem_q[rptr_q[DEPTH_W-1:0]];
    end
  end

  ipml_prefetch_obuf #(
    .DATA_W (DATA_W)
  ) u_obuf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_vld   (inflight_q),
    .in_data  (ram_rdata_q),
    .pop      (pop_s),
    .out_data (rd_data),
    .out_vld  (rd_vld_s),
    .buf_cnt  (buf_cnt_s)
  );

  assign rd_vld       = rd_vld_s;
  assign wr_vld       = wr_vld_q;
  assign level        = level_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
